// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU operand/result and response signals between the issuer and its environment.
// The master modport is the issuer; the slave modport is the command source, ALU and response sink.
interface alu_cmd_issuer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;
  logic [WIDTH-1:0] alu_num1;
  logic [WIDTH-1:0] alu_num2;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_ans;
  logic [2:0]       alu_flag;
  logic             alu_error;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_flag;
  logic             rsp_error;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    input  alu_ans, alu_flag, alu_error, rsp_ready,
    output cmd_ready, alu_num1, alu_num2, alu_sel,
    output rsp_valid, rsp_data, rsp_flag, rsp_error
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    output alu_ans, alu_flag, alu_error, rsp_ready,
    input  cmd_ready, alu_num1, alu_num2, alu_sel,
    input  rsp_valid, rsp_data, rsp_flag, rsp_error
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues commands to an external combinational ALU and returns its captured result as a response,
// optionally chaining the last good result in as operand A.
module alu_cmd_issuer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ERRW  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  alu_cmd_issuer_if.master bus,
  output logic             busy,
  output logic [ERRW-1:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]       rsp_flag_q, rsp_flag_d;
  logic             rsp_err_q, rsp_err_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             load_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      num1_q     <= '0;
      num2_q     <= '0;
      sel_q      <= '0;
      last_q     <= '0;
      rsp_data_q <= '0;
      rsp_flag_q <= '0;
      rsp_err_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      rsp_data_q <= rsp_data_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_err_q  <= rsp_err_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    sel_d      = sel_q;
    last_d     = last_q;
    rsp_data_d = rsp_data_q;
    rsp_flag_d = rsp_flag_q;
    rsp_err_d  = rsp_err_q;
    err_d      = err_q;
    load_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          load_c  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_flag_d = bus.alu_flag;
        rsp_err_d  = bus.alu_error;
        state_d    = DONE;
        if (!bus.alu_error) begin
          rsp_data_d = bus.alu_ans;
          last_d     = bus.alu_ans;
        end else begin
          rsp_data_d = '0;
          if (err_q != '1) err_d = err_q + ERRW'(1);
        end
      end
      DONE: begin
        // Handshake completing with a command waiting re-enters EXEC directly.
        if (bus.rsp_ready) begin
          if (bus.cmd_valid) begin
            load_c  = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      num1_d = bus.cmd_chain ? last_q : bus.cmd_a;
      num2_d = bus.cmd_b;
      sel_d  = bus.cmd_op;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) || ((state_q == DONE) && bus.rsp_ready);
  assign bus.alu_num1  = num1_q;
  assign bus.alu_num2  = num2_q;
  assign bus.alu_sel   = sel_q;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign bus.rsp_error = rsp_err_q;
  assign busy          = (state_q != IDLE);
  assign err_count     = err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: two instances (ERRW=8 and ERRW=2) run in lockstep on the
// same command stream, each driving its own ALU model.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_chain;
  logic        rsp_ready;
  logic        busy;
  logic [7:0]  err_count;
  logic        sat_busy;
  logic [1:0]  sat_err;
  int          checks;
  int          failures;

  alu_cmd_issuer_if #(.WIDTH(32)) bus ();
  alu_cmd_issuer_if #(.WIDTH(32)) sat_bus ();

  alu_cmd_issuer #(.WIDTH(32), .ERRW(8)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .err_count(err_count)
  );

  alu_cmd_issuer #(.WIDTH(32), .ERRW(2)) u_sat (
    .clk(clk), .rstn(rstn), .bus(sat_bus), .busy(sat_busy), .err_count(sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {error, lt_unsigned, lt_signed, eq, ans}; junk ans on error.
  function automatic logic [35:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (s)
      4'd0: r = a - b;
      4'd1: r = a + b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      default: begin
        e = 1'b1;
        r = a ^ 32'hDEAD_BEEF;
      end
    endcase
    return {e, a < b, $signed(a) < $signed(b), a == b, r};
  endfunction

  logic [35:0] alu_m, sat_alu_m;
  assign alu_m              = alu_f(bus.alu_sel, bus.alu_num1, bus.alu_num2);
  assign sat_alu_m          = alu_f(sat_bus.alu_sel, sat_bus.alu_num1, sat_bus.alu_num2);
  assign bus.alu_ans        = alu_m[31:0];
  assign bus.alu_flag       = alu_m[34:32];
  assign bus.alu_error      = alu_m[35];
  assign sat_bus.alu_ans    = sat_alu_m[31:0];
  assign sat_bus.alu_flag   = sat_alu_m[34:32];
  assign sat_bus.alu_error  = sat_alu_m[35];

  assign bus.cmd_valid     = cmd_valid;
  assign bus.cmd_op        = cmd_op;
  assign bus.cmd_a         = cmd_a;
  assign bus.cmd_b         = cmd_b;
  assign bus.cmd_chain     = cmd_chain;
  assign bus.rsp_ready     = rsp_ready;
  assign sat_bus.cmd_valid = cmd_valid;
  assign sat_bus.cmd_op    = cmd_op;
  assign sat_bus.cmd_a     = cmd_a;
  assign sat_bus.cmd_b     = cmd_b;
  assign sat_bus.cmd_chain = cmd_chain;
  assign sat_bus.rsp_ready = rsp_ready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command until accepted; returns one cycle after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ch);
    bit ok;
    ok        = 1'b0;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = ch;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (bus.cmd_ready === 1'b1) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      failures++;
      $display("FAIL issue_timeout: cmd_ready got %b required 1 within 10 cycles", bus.cmd_ready);
    end
  endtask

  // Counts cycles from the accept cycle until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid got %b required 1 within 12 cycles", bus.rsp_valid);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b required 0", bus.rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_err_count: got %0d required 0", err_count); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready: got %b required 1", bus.cmd_ready); end
    checks++; if ({bus.alu_num1, bus.alu_num2, bus.alu_sel} !== 68'd0) begin failures++; $display("FAIL rst_alu_regs: got %0h required 0", {bus.alu_num1, bus.alu_num2, bus.alu_sel}); end
    checks++; if ({bus.rsp_data, bus.rsp_flag, bus.rsp_error} !== 36'd0) begin failures++; $display("FAIL rst_rsp_regs: got %0h required 0", {bus.rsp_data, bus.rsp_flag, bus.rsp_error}); end
    rstn = 1'b1;
    issue(4'd1, 32'd9, 32'd9, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL exec_busy: got %b required 1", busy); end
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid: got %b required 0", bus.rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL midrst_err_count: got %0d required 0", err_count); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_cmd_ready: got %b required 1", bus.cmd_ready); end
    checks++; if (bus.alu_num1 !== 32'd0) begin failures++; $display("FAIL midrst_num1: got %0h required 0", bus.alu_num1); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL postrst_rsp_valid: got %b required 0", bus.rsp_valid); end
  endtask

  task automatic test_add();
    int lat;
    issue(4'd1, 32'd5, 32'd7, 1'b0);
    checks++; if ({bus.alu_num1, bus.alu_num2, bus.alu_sel} !== {32'd5, 32'd7, 4'd1}) begin failures++; $display("FAIL add_alu_regs: got %0h required %0h", {bus.alu_num1, bus.alu_num2, bus.alu_sel}, {32'd5, 32'd7, 4'd1}); end
    wait_rsp(lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL add_latency: got %0d required 2", lat); end
    checks++; if (bus.rsp_data !== 32'd12) begin failures++; $display("FAIL add_data: got %0d required 12", bus.rsp_data); end
    checks++; if (bus.rsp_error !== 1'b0) begin failures++; $display("FAIL add_error: got %b required 0", bus.rsp_error); end
    checks++; if (bus.rsp_flag !== 3'b110) begin failures++; $display("FAIL add_flag: got %b required 110", bus.rsp_flag); end
    consume();
  endtask

  task automatic test_chain();
    int lat;
    issue(4'd6, 32'd3, 32'd4, 1'b0);
    wait_rsp(lat);
    checks++; if (bus.rsp_data !== 32'd48) begin failures++; $display("FAIL chain_lmv: got %0d required 48", bus.rsp_data); end
    consume();
    issue(4'd0, 32'h1234, 32'd8, 1'b1);
    checks++; if (bus.alu_num1 !== 32'd48) begin failures++; $display("FAIL chain_num1: got %0d required 48", bus.alu_num1); end
    wait_rsp(lat);
    checks++; if (bus.rsp_data !== 32'd40) begin failures++; $display("FAIL chain_sub: got %0d required 40", bus.rsp_data); end
    consume();
    issue(4'd15, 32'h5555, 32'd0, 1'b1);
    wait_rsp(lat);
    checks++; if (bus.rsp_error !== 1'b1) begin failures++; $display("FAIL chain_err_flag: got %b required 1", bus.rsp_error); end
    checks++; if (bus.rsp_data !== 32'd0) begin failures++; $display("FAIL chain_err_data: got %0h required 0", bus.rsp_data); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL chain_err_count: got %0d required 1", err_count); end
    consume();
    issue(4'd1, 32'h9999, 32'd2, 1'b1);
    checks++; if (bus.alu_num1 !== 32'd40) begin failures++; $display("FAIL chain_after_err_num1: got %0d required 40", bus.alu_num1); end
    wait_rsp(lat);
    checks++; if (bus.rsp_data !== 32'd42) begin failures++; $display("FAIL chain_add: got %0d required 42", bus.rsp_data); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    rsp_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd2, 1'b0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      cmd_op = 4'd1; cmd_a = 32'd7; cmd_b = 32'd7; cmd_chain = 1'b0; cmd_valid = 1'b1;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b required 1", i, bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL bp_data[%0d]: got %0h required ffffffff", i, bus.rsp_data); end
      checks++; if (bus.rsp_flag !== 3'b110) begin failures++; $display("FAIL bp_flag[%0d]: got %b required 110", i, bus.rsp_flag); end
      checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready[%0d]: got %b required 0", i, bus.cmd_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy[%0d]: got %b required 1", i, busy); end
      tick();
    end
    checks++; if (bus.alu_num1 !== 32'd1) begin failures++; $display("FAIL bp_num1_held: got %0h required 1", bus.alu_num1); end
    cmd_valid = 1'b0;
    consume();
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got busy=%b valid=%b required 0/0", busy, bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    int          nrsp;
    va[0] = 32'h0000_00F0; vb[0] = 32'h0000_000F;
    va[1] = 32'hAAAA_AAAA; vb[1] = 32'hFFFF_0000;
    va[2] = 32'h1234_5678; vb[2] = 32'h1234_5678;
    va[3] = 32'h8000_0001; vb[3] = 32'h0000_0003;
    nrsp = 0;
    rsp_ready = 1'b1;
    cmd_op = 4'd4; cmd_chain = 1'b0; cmd_a = va[0]; cmd_b = vb[0]; cmd_valid = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_ready: got %b required 1", bus.cmd_ready); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if ({bus.alu_num1, bus.alu_num2, bus.alu_sel} !== {va[k], vb[k], 4'd4}) begin failures++; $display("FAIL b2b_alu_regs[%0d]: got %0h required %0h", k, {bus.alu_num1, bus.alu_num2, bus.alu_sel}, {va[k], vb[k], 4'd4}); end
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_exec_valid[%0d]: got %b required 0", k, bus.rsp_valid); end
      if (k < 3) begin
        cmd_a = va[k+1]; cmd_b = vb[k+1];
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      if (bus.rsp_valid === 1'b1) nrsp++;
      checks++; if (bus.rsp_data !== (va[k] ^ vb[k])) begin failures++; $display("FAIL b2b_data[%0d]: got %0h required %0h", k, bus.rsp_data, va[k] ^ vb[k]); end
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_done_ready[%0d]: got %b required 1", k, bus.cmd_ready); end
      tick();
    end
    checks++; if (nrsp != 4) begin failures++; $display("FAIL b2b_rsp_count: got %0d required 4", nrsp); end
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got valid=%b busy=%b required 0/0", bus.rsp_valid, busy); end
  endtask

  task automatic test_saturation();
    int lat;
    issue(4'd1, 32'd10, 32'd5, 1'b0);
    wait_rsp(lat);
    checks++; if (bus.rsp_data !== 32'd15 || sat_bus.rsp_data !== 32'd15) begin failures++; $display("FAIL sat_seed: got %0d/%0d required 15/15", bus.rsp_data, sat_bus.rsp_data); end
    consume();
    for (int k = 0; k < 5; k++) begin
      issue(4'd9, 32'(k), 32'(k), 1'b1);
      wait_rsp(lat);
      checks++; if (sat_bus.rsp_error !== 1'b1) begin failures++; $display("FAIL sat_rsp_error[%0d]: got %b required 1", k, sat_bus.rsp_error); end
      checks++; if (err_count !== 8'(k + 2)) begin failures++; $display("FAIL sat_wide_count[%0d]: got %0d required %0d", k, err_count, k + 2); end
      checks++; if (sat_err !== ((k == 0) ? 2'd2 : 2'd3)) begin failures++; $display("FAIL sat_narrow_count[%0d]: got %0d required %0d", k, sat_err, (k == 0) ? 2 : 3); end
      consume();
    end
    issue(4'd1, 32'hABCD, 32'd0, 1'b1);
    wait_rsp(lat);
    checks++; if (bus.rsp_data !== 32'd15 || sat_bus.rsp_data !== 32'd15) begin failures++; $display("FAIL sat_last_result: got %0d/%0d required 15/15", bus.rsp_data, sat_bus.rsp_data); end
    consume();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add();
    test_chain();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
